// File: rtl/bs_ctrl.sv
// bs_ctrl: paces LZ77 tokens and the Adler-32 checksum into a bitstream writer for one frame.
module bs_ctrl #(
  parameter int LIT_DAT_WD = 8,
  parameter int LEN_DAT_WD = 7,
  parameter int DIS_DAT_WD = 7,
  parameter int INIT_CYC   = 10,
  parameter int GAP_CYC    = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  tok_val_i,
  output logic                  tok_rdy_o,
  input  logic                  tok_flg_lit_i,
  input  logic [LIT_DAT_WD-1:0] tok_lit_i,
  input  logic [LEN_DAT_WD-1:0] tok_len_i,
  input  logic [DIS_DAT_WD-1:0] tok_dis_i,
  input  logic                  tok_lst_i,
  input  logic                  adler_done_i,
  input  logic [31:0]           adler_dat_i,
  output logic                  bs_start_o,
  output logic                  bs_val_o,
  output logic                  bs_flg_lit_o,
  output logic [LIT_DAT_WD-1:0] bs_lit_o,
  output logic [LEN_DAT_WD-1:0] bs_len_o,
  output logic [DIS_DAT_WD-1:0] bs_dis_o,
  output logic                  bs_lst_o,
  output logic                  bs_adler_done_o,
  output logic [31:0]           bs_adler_dat_o,
  input  logic                  bs_done_i,
  output logic                  done_o
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] INIT      = 3'd2;
  localparam logic [2:0] WAIT_TOK  = 3'd3;
  localparam logic [2:0] GAP       = 3'd4;
  localparam logic [2:0] WAIT_ADL  = 3'd5;
  localparam logic [2:0] WAIT_DONE = 3'd6;
  localparam logic [2:0] DONE      = 3'd7;
  localparam int CW = $clog2((INIT_CYC > GAP_CYC ? INIT_CYC : GAP_CYC) + 1);

  logic [2:0]            st_q, st_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  lst_q, lst_d;
  logic                  latch_q, latch_d;
  logic [31:0]           adl_q, adl_d;
  logic                  val_q, adl_done_q;
  logic                  flg_q, blst_q;
  logic [LIT_DAT_WD-1:0] lit_q;
  logic [LEN_DAT_WD-1:0] len_q;
  logic [DIS_DAT_WD-1:0] dis_q;
  logic                  xfer, launch;

  assign xfer   = tok_val_i && st_q == WAIT_TOK;
  // a checksum arriving during WAIT_ADL itself is launched straight away
  assign launch = st_q == WAIT_ADL && (latch_q || adler_done_i);

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    lst_d   = lst_q;
    latch_d = latch_q;
    adl_d   = adl_q;
    if (st_q != IDLE && !latch_q && adler_done_i) begin
      latch_d = 1'b1;
      adl_d   = adler_dat_i;
    end
    case (st_q)
      IDLE: if (start_i) begin
        st_d    = START;
        latch_d = 1'b0;
        lst_d   = 1'b0;
      end
      START: begin
        st_d  = INIT;
        cnt_d = CW'(INIT_CYC - 1);
      end
      INIT: begin
        st_d  = cnt_q == '0 ? WAIT_TOK : INIT;
        cnt_d = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
      end
      WAIT_TOK: if (xfer) begin
        st_d  = GAP;
        cnt_d = CW'(GAP_CYC - 1);
        lst_d = tok_lst_i;
      end
      GAP: begin
        st_d  = cnt_q != '0 ? GAP : lst_q ? WAIT_ADL : WAIT_TOK;
        cnt_d = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
      end
      WAIT_ADL:  st_d = launch ? WAIT_DONE : WAIT_ADL;
      WAIT_DONE: st_d = bs_done_i ? DONE : WAIT_DONE;
      default:   st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= IDLE;
      cnt_q      <= '0;
      lst_q      <= 1'b0;
      latch_q    <= 1'b0;
      adl_q      <= '0;
      val_q      <= 1'b0;
      adl_done_q <= 1'b0;
      flg_q      <= 1'b0;
      blst_q     <= 1'b0;
      lit_q      <= '0;
      len_q      <= '0;
      dis_q      <= '0;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      lst_q      <= lst_d;
      latch_q    <= latch_d;
      adl_q      <= adl_d;
      val_q      <= xfer;
      adl_done_q <= launch;
      if (xfer) begin
        flg_q  <= tok_flg_lit_i;
        blst_q <= tok_lst_i;
        lit_q  <= tok_lit_i;
        len_q  <= tok_len_i;
        dis_q  <= tok_dis_i;
      end
    end
  end

  assign tok_rdy_o       = st_q == WAIT_TOK;
  assign bs_start_o      = st_q == START;
  assign done_o          = st_q == DONE;
  assign bs_val_o        = val_q;
  assign bs_flg_lit_o    = flg_q;
  assign bs_lit_o        = lit_q;
  assign bs_len_o        = len_q;
  assign bs_dis_o        = dis_q;
  assign bs_lst_o        = blst_q;
  assign bs_adler_done_o = adl_done_q;
  assign bs_adler_dat_o  = adl_q;
endmodule

// File: tb/tb_bs_ctrl.sv
// tb_bs_ctrl: directed frames for bs_ctrl; expected writer-side events are queued and checked by a monitor.
module tb_bs_ctrl;
  logic clk = 0, rst = 1, start_i = 0, tok_val_i = 0, tok_flg_lit_i = 0, tok_lst_i = 0;
  logic [7:0] tok_lit_i = 0;
  logic [6:0] tok_len_i = 0, tok_dis_i = 0;
  logic adler_done_i = 0, bs_done_i = 0;
  logic [31:0] adler_dat_i = 0;
  logic tok_rdy_o, bs_start_o, bs_val_o, bs_flg_lit_o, bs_lst_o, bs_adler_done_o, done_o;
  logic [7:0] bs_lit_o;
  logic [6:0] bs_len_o, bs_dis_o;
  logic [31:0] bs_adler_dat_o;

  bs_ctrl dut (
    .clk(clk), .rst(rst), .start_i(start_i), .tok_val_i(tok_val_i), .tok_rdy_o(tok_rdy_o),
    .tok_flg_lit_i(tok_flg_lit_i), .tok_lit_i(tok_lit_i), .tok_len_i(tok_len_i),
    .tok_dis_i(tok_dis_i), .tok_lst_i(tok_lst_i), .adler_done_i(adler_done_i),
    .adler_dat_i(adler_dat_i), .bs_start_o(bs_start_o), .bs_val_o(bs_val_o),
    .bs_flg_lit_o(bs_flg_lit_o), .bs_lit_o(bs_lit_o), .bs_len_o(bs_len_o), .bs_dis_o(bs_dis_o),
    .bs_lst_o(bs_lst_o), .bs_adler_done_o(bs_adler_done_o), .bs_adler_dat_o(bs_adler_dat_o),
    .bs_done_i(bs_done_i), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    logic flg;
    logic [7:0] lit;
    logic [6:0] len;
    logic [6:0] dis;
    logic lst;
    logic [31:0] adl;
    int dt;
  } exp_t;

  exp_t q[$];
  int total = 0, bad = 0, cyc = 0, last_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", n, got, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input int kind, input int dt);
    exp_t e;
    e = '{kind: kind, flg: 0, lit: 0, len: 0, dis: 0, lst: 0, adl: 0, dt: dt};
    return e;
  endfunction

  task automatic ev(input int k);
    exp_t e;
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event got=kind%0d exp=none (cycle %0d)", k, cyc);
    end else begin
      e = q.pop_front();
      chk("ev_kind", 64'(k), 64'(e.kind));
      if (k == 1) begin
        chk("bs_flg_lit", 64'(bs_flg_lit_o), 64'(e.flg));
        chk("bs_lit", 64'(bs_lit_o), 64'(e.lit));
        chk("bs_len", 64'(bs_len_o), 64'(e.len));
        chk("bs_dis", 64'(bs_dis_o), 64'(e.dis));
        chk("bs_lst", 64'(bs_lst_o), 64'(e.lst));
      end
      if (k == 2) chk("bs_adler_dat", 64'(bs_adler_dat_o), 64'(e.adl));
      if (e.dt >= 0) chk("ev_spacing", 64'(cyc - last_cyc), 64'(e.dt));
    end
    last_cyc = cyc;
  endtask

  always @(negedge clk) if (!rst) begin
    if (bs_start_o) ev(0);
    if (bs_val_o) ev(1);
    if (bs_adler_done_o) ev(2);
    if (done_o) ev(3);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    q.push_back(mk(0, -1));
    start_i = 1;
    tick();
    start_i = 0;
  endtask

  task automatic send(input logic flg, input logic [7:0] lit, input logic [6:0] len,
                      input logic [6:0] dis, input logic lst, input int dt);
    exp_t e;
    bit ok = 0;
    e = mk(1, dt);
    e.flg = flg; e.lit = lit; e.len = len; e.dis = dis; e.lst = lst;
    q.push_back(e);
    tok_val_i = 1; tok_flg_lit_i = flg; tok_lit_i = lit; tok_len_i = len; tok_dis_i = dis; tok_lst_i = lst;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tok_rdy_o) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("tok_handshake_timeout", 0, 1);
    tick();
  endtask

  task automatic pulse_adler(input logic [31:0] v);
    adler_done_i = 1;
    adler_dat_i = v;
    tick();
    adler_done_i = 0;
  endtask

  task automatic finish_frame();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bs_adler_done_o) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("adler_launch_timeout", 0, 1);
    q.push_back(mk(3, 5));
    repeat (4) tick();
    bs_done_i = 1;
    tick();
    bs_done_i = 0;
  endtask

  initial begin
    exp_t e;
    #1000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_outputs", 64'({bs_start_o, bs_val_o, tok_rdy_o, done_o, bs_adler_done_o, bs_flg_lit_o,
                            bs_lst_o, bs_lit_o, bs_len_o, bs_dis_o}), 0);
    chk("rst_adler_dat", 64'(bs_adler_dat_o), 0);
    tick();
    rst = 0;
    tick();
    // frame A: held-valid tokens, early checksum, ignored duplicate checksum and early writer done
    start_frame();
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      chk("rdy_low_init", 64'(tok_rdy_o), 0);
      tick();
    end
    send(1, 8'h41, 0, 0, 0, 12);
    pulse_adler(32'h1234ABCD);
    send(1, 8'h42, 0, 0, 0, 11);
    bs_done_i = 1;
    pulse_adler(32'hDEADBEEF);
    bs_done_i = 0;
    e = mk(1, 11);
    e.len = 5; e.dis = 3; e.lst = 1;
    send(0, 8'h00, 7'd5, 7'd3, 1, 11);
    tok_val_i = 0;
    e = mk(2, 11);
    e.adl = 32'h1234ABCD;
    q.push_back(e);
    finish_frame();
    repeat (2) tick();
    @(negedge clk);
    chk("idle_rdy", 64'(tok_rdy_o), 0);
    chk("hold_lst", 64'(bs_lst_o), 1);
    chk("hold_adler_dat", 64'(bs_adler_dat_o), 64'h1234ABCD);
    tick();
    // frame B: stalled upstream, start_i ignored in WAIT_TOK, checksum arriving in WAIT_ADL as a level
    start_frame();
    send(1, 8'h10, 0, 0, 0, 12);
    tok_val_i = 0;
    repeat (15) tick();
    @(negedge clk);
    chk("rdy_wait_tok", 64'(tok_rdy_o), 1);
    tick();
    start_i = 1;
    tick();
    start_i = 0;
    send(0, 8'h00, 7'd7, 7'd100, 1, -1);
    tok_val_i = 0;
    repeat (13) tick();
    e = mk(2, 14);
    e.adl = 32'hCAFEF00D;
    q.push_back(e);
    adler_done_i = 1;
    adler_dat_i = 32'hCAFEF00D;
    repeat (3) tick();
    adler_done_i = 0;
    q.push_back(mk(3, 5));
    repeat (2) tick();
    bs_done_i = 1;
    tick();
    bs_done_i = 0;
    repeat (2) tick();
    @(negedge clk);
    chk("hold_adler_dat_b", 64'(bs_adler_dat_o), 64'hCAFEF00D);
    tick();
    // frame C: reset in GAP abandons the frame silently
    start_frame();
    send(1, 8'h55, 0, 0, 0, 12);
    tok_val_i = 0;
    repeat (3) tick();
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chk("gap_rst_outputs", 64'({bs_start_o, bs_val_o, tok_rdy_o, done_o, bs_adler_done_o, bs_flg_lit_o,
                                bs_lst_o, bs_lit_o, bs_len_o, bs_dis_o}), 0);
    chk("gap_rst_adler_dat", 64'(bs_adler_dat_o), 0);
    repeat (20) tick();
    // frame D: normal single-token frame after the reset
    start_frame();
    send(1, 8'h99, 0, 0, 1, 12);
    tok_val_i = 0;
    e = mk(2, 11);
    e.adl = 32'h0BADCAFE;
    q.push_back(e);
    pulse_adler(32'h0BADCAFE);
    finish_frame();
    repeat (5) tick();
    chk("queue_empty", 64'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
